// File: rtl/pa_core_td_gen2_pkg.sv
// Shared opcodes, instruction field positions and ALU source encoding
// for the pa_core_td_gen2 accumulator core.
package pa_core_pkg;

  localparam int OPC_W   = 4;
  localparam int IMM_LSB = 0;

  localparam logic [OPC_W-1:0] OP_ADD_A  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_MOV_AB = 4'b0001;
  localparam logic [OPC_W-1:0] OP_IN_A   = 4'b0010;
  localparam logic [OPC_W-1:0] OP_MOV_AI = 4'b0011;
  localparam logic [OPC_W-1:0] OP_MOV_BA = 4'b0100;
  localparam logic [OPC_W-1:0] OP_ADD_B  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_IN_B   = 4'b0110;
  localparam logic [OPC_W-1:0] OP_MOV_BI = 4'b0111;
  localparam logic [OPC_W-1:0] OP_OUT_A  = 4'b1000;
  localparam logic [OPC_W-1:0] OP_OUT_B  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_NOP    = 4'b1010;
  localparam logic [OPC_W-1:0] OP_OUT_I  = 4'b1011;
  localparam logic [OPC_W-1:0] OP_JMP_A  = 4'b1100;
  localparam logic [OPC_W-1:0] OP_JMP_B  = 4'b1101;
  localparam logic [OPC_W-1:0] OP_JNC    = 4'b1110;
  localparam logic [OPC_W-1:0] OP_JMP_I  = 4'b1111;

  // The low two opcode bits select the adder source for every opcode.
  typedef enum logic [1:0] {
    SRC_A    = 2'b00,
    SRC_B    = 2'b01,
    SRC_IN   = 2'b10,
    SRC_ZERO = 2'b11
  } src_sel_e;

  function automatic src_sel_e op_src(input logic [OPC_W-1:0] op);
    return src_sel_e'(op[1:0]);
  endfunction

endpackage

// File: rtl/pa_core_td_gen2_if.sv
// Bundle between the core sequencer and its adder: operands and source
// select in, sum and carry-out back.
interface pa_core_td_gen2_if #(parameter int DATA_W = 4);
  import pa_core_pkg::*;

  src_sel_e          src_sel;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] in_val;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] sum;
  logic              carry_out;

  modport master (output src_sel, a, b, in_val, imm, input sum, carry_out);
  modport slave  (input src_sel, a, b, in_val, imm, output sum, carry_out);

endinterface

// File: rtl/pa_core_alu.sv
// Combinational source mux plus DATA_W+1 bit adder; carry-out is the
// adder's top bit.
module pa_core_alu
  import pa_core_pkg::*;
#(
  parameter int DATA_W = 4
) (
  pa_core_td_gen2_if.slave alu
);

  logic [DATA_W-1:0] src;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    src = '0;
    unique case (alu.src_sel)
      SRC_A:    src = alu.a;
      SRC_B:    src = alu.b;
      SRC_IN:   src = alu.in_val;
      SRC_ZERO: src = '0;
    endcase
  end

  assign {alu.carry_out, alu.sum} = {1'b0, src} + {1'b0, alu.imm};

endmodule

// File: rtl/pa_core_td_gen2.sv
// Parametrised A/B accumulator core with carry, JNC, stall and output strobe.
// Optional input synchroniser selected by macro PA_CORE_INPUT_SYNC_EN.
module pa_core_td_gen2
  import pa_core_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = OPC_W + DATA_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  input  logic [DATA_W-1:0]  input_i,
  output logic [DATA_W-1:0]  output_o,
  output logic               output_vld_o,
  output logic               carry_o
);

  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] in_val;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              vld_q, vld_d;
  logic              carry_q, carry_d;

  assign opcode = imem_data_i[INSTR_W-1 -: OPC_W];
  assign imm    = imem_data_i[IMM_LSB +: DATA_W];

`ifdef PA_CORE_INPUT_SYNC_EN
  logic [DATA_W-1:0] sync_meta_q;
  logic [DATA_W-1:0] sync_q;

  // Free-running so the synchroniser keeps tracking input_i during stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= input_i;
      sync_q      <= sync_meta_q;
    end
  end

  assign in_val = sync_q;
`else
  assign in_val = input_i;
`endif

  pa_core_td_gen2_if #(.DATA_W(DATA_W)) alu_bus ();

  assign alu_bus.src_sel = op_src(opcode);
  assign alu_bus.a       = a_q;
  assign alu_bus.b       = b_q;
  assign alu_bus.in_val  = in_val;
  assign alu_bus.imm     = imm;

  pa_core_alu #(.DATA_W(DATA_W)) u_alu (.alu(alu_bus.slave));

  always_comb begin
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    carry_d = carry_q;
    if (en_i) begin
      pc_d = pc_q + ADDR_W'(1);
      if (!opcode[OPC_W-1]) begin
        // Register writes: bit 2 picks B over A; only these touch carry.
        carry_d = alu_bus.carry_out;
        if (opcode[2]) b_d = alu_bus.sum;
        else           a_d = alu_bus.sum;
      end else begin
        case (opcode)
          OP_OUT_A, OP_OUT_B, OP_OUT_I: begin
            out_d = alu_bus.sum;
            vld_d = 1'b1;
          end
          OP_JMP_A, OP_JMP_B, OP_JMP_I: pc_d = alu_bus.sum[ADDR_W-1:0];
          OP_JNC: if (!carry_q) pc_d = imm[ADDR_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      carry_q <= carry_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign output_o     = out_q;
  assign output_vld_o = vld_q;
  assign carry_o      = carry_q;

endmodule

// File: tb/tb_pa_core_td_gen2.sv
// Self-checking bench: directed vector tables for both core sizes, a
// standalone adder check, and a random run against a spec-level model.
module tb_pa_core_td_gen2;
  import pa_core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 4-bit data / 16-word core
  logic       rst4, en4;
  logic [3:0] in4, addr4, out4;
  logic [7:0] idata4;
  logic       vld4, carry4;
  logic [7:0] mem4 [16];
  assign idata4 = mem4[addr4];

  pa_core_td_gen2 #(.DATA_W(4), .ADDR_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst4), .en_i(en4), .imem_addr_o(addr4),
    .imem_data_i(idata4), .input_i(in4), .output_o(out4),
    .output_vld_o(vld4), .carry_o(carry4)
  );

  // 8-bit data / 64-word core
  logic        rst8, en8;
  logic [7:0]  in8, out8;
  logic [5:0]  addr8;
  logic [11:0] idata8;
  logic        vld8, carry8;
  logic [11:0] mem8 [64];
  assign idata8 = mem8[addr8];

  pa_core_td_gen2 #(.DATA_W(8), .ADDR_W(6)) dut8 (
    .clk_i(clk), .rst_i(rst8), .en_i(en8), .imem_addr_o(addr8),
    .imem_data_i(idata8), .input_i(in8), .output_o(out8),
    .output_vld_o(vld8), .carry_o(carry8)
  );

  // Standalone adder on its own bus
  pa_core_td_gen2_if #(.DATA_W(4)) alu_bus_tb ();
  pa_core_alu #(.DATA_W(4)) alu_tb (.alu(alu_bus_tb.slave));

  typedef struct {
    bit   sel8;
    bit   rst;
    bit   en;
    int   din;
    int   addr;
    int   out;
    bit   vld;
    bit   carry;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(bit sel8, bit rst, bit en, int din, int addr, int out, bit vld, bit carry);
    row_t r;
    r.sel8 = sel8; r.rst = rst; r.en = en; r.din = din;
    r.addr = addr; r.out = out; r.vld = vld; r.carry = carry;
    return r;
  endfunction

  task automatic run_rows(input string tag);
    foreach (rows[i]) begin
      row_t r;
      r = rows[i];
      if (r.sel8) begin rst8 = r.rst; en8 = r.en; in8 = 8'(r.din); end
      else        begin rst4 = r.rst; en4 = r.en; in4 = 4'(r.din); end
      @(posedge clk); #1;
      if (r.sel8) begin
        check($sformatf("%s[%0d].addr", tag, i), 32'(addr8), r.addr);
        check($sformatf("%s[%0d].out", tag, i), 32'(out8), r.out);
        check($sformatf("%s[%0d].vld", tag, i), 32'(vld8), 32'(r.vld));
        check($sformatf("%s[%0d].carry", tag, i), 32'(carry8), 32'(r.carry));
      end else begin
        check($sformatf("%s[%0d].addr", tag, i), 32'(addr4), r.addr);
        check($sformatf("%s[%0d].out", tag, i), 32'(out4), r.out);
        check($sformatf("%s[%0d].vld", tag, i), 32'(vld4), 32'(r.vld));
        check($sformatf("%s[%0d].carry", tag, i), 32'(carry4), 32'(r.carry));
      end
    end
    rows.delete();
  endtask

  // Spec-level model of the 4-bit core: one call per clock edge.
  typedef struct {
    int pc, a, b, out, vld, c, s1, s2;
  } mstate_t;

  function automatic mstate_t model_step(mstate_t s, int instr, bit rst, bit en, int din);
    mstate_t n;
    int op, imm, src, sum, in_eff;
    n = s;
`ifdef PA_CORE_INPUT_SYNC_EN
    in_eff = s.s2;
`else
    in_eff = din;
`endif
    n.s1 = din;
    n.s2 = s.s1;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    n.vld = 0;
    if (!en) return n;
    op  = (instr >> 4) & 15;
    imm = instr & 15;
    case (op)
      0, 4, 8, 12: src = s.a;
      1, 5, 9, 13: src = s.b;
      2, 6:        src = in_eff;
      default:     src = 0;
    endcase
    sum  = src + imm;
    n.pc = (s.pc + 1) % 16;
    case (op)
      0, 1, 2, 3: begin n.a = sum % 16; n.c = sum / 16; end
      4, 5, 6, 7: begin n.b = sum % 16; n.c = sum / 16; end
      8, 9, 11:   begin n.out = sum % 16; n.vld = 1; end
      12, 13, 15: n.pc = sum % 16;
      14:         if (s.c == 0) n.pc = imm;
      default: ;
    endcase
    return n;
  endfunction

  initial begin
    mstate_t m;
    int exp_late;

    rst4 = 1'b1; en4 = 1'b1; in4 = '0;
    rst8 = 1'b1; en8 = 1'b0; in8 = '0;
    foreach (mem4[i]) mem4[i] = 8'($urandom_range(0, 255));
    foreach (mem8[i]) mem8[i] = 12'hA00;

    // Reset with random instructions on the fetch port
    repeat (2) @(posedge clk);
    #1;
    check("rst.addr", 32'(addr4), 0);
    check("rst.out", 32'(out4), 0);
    check("rst.vld", 32'(vld4), 0);
    check("rst.carry", 32'(carry4), 0);

    // OUT Im 1,2,4,8 across all 16 words, wrapping
    foreach (mem4[i]) mem4[i] = {4'hB, 4'(1 << (i % 4))};
    rst4 = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      check($sformatf("outi[%0d].addr", k), 32'(addr4), (k + 1) % 16);
      check($sformatf("outi[%0d].out", k), 32'(out4), 1 << (k % 4));
      check($sformatf("outi[%0d].vld", k), 32'(vld4), 1);
    end

    // Carry / JNC with stalls
    foreach (mem4[i]) mem4[i] = 8'hA0;
    mem4[0] = 8'h3F; mem4[1] = 8'h01; mem4[2] = 8'hE9;
    mem4[3] = 8'h01; mem4[4] = 8'hE9; mem4[9] = 8'h80;
    rows.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 2, 0, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 2, 0, 0, 1));
    rows.push_back(mk(0, 0, 0, 0, 2, 0, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 3, 0, 0, 1));
    rows.push_back(mk(0, 0, 1, 0, 4, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 9, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 10, 1, 1, 0));
    rows.push_back(mk(0, 0, 0, 0, 10, 1, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 10, 1, 0, 0));
    rows.push_back(mk(0, 0, 0, 0, 10, 1, 0, 0));
    rows.push_back(mk(0, 0, 1, 0, 11, 1, 0, 0));
    run_rows("jnc");

    // Input path: steady input, then a late change just before IN
`ifdef PA_CORE_INPUT_SYNC_EN
    exp_late = 'hA;
`else
    exp_late = 'h5;
`endif
    foreach (mem4[i]) mem4[i] = 8'hA0;
    mem4[0] = 8'h20; mem4[1] = 8'h80;
    rows.push_back(mk(0, 1, 1, 'hA, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 'hA, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 'hA, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 'hA, 1, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 'hA, 2, 'hA, 1, 0));
    rows.push_back(mk(0, 1, 1, 'hA, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 'hA, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 'hA, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 0, 'h5, 0, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 'h5, 1, 0, 0, 0));
    rows.push_back(mk(0, 0, 1, 'h5, 2, exp_late, 1, 0));
    run_rows("input");

    // Wide core: 8-bit carry, jump to last word and wrap, reset while stalled
    mem8[0] = 12'h7FF; mem8[1] = 12'h501; mem8[2] = 12'h900;
    mem8[3] = 12'hF3F; mem8[63] = 12'hB77;
    rows.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0));
    rows.push_back(mk(1, 0, 1, 0, 2, 0, 0, 1));
    rows.push_back(mk(1, 0, 1, 0, 3, 0, 1, 1));
    rows.push_back(mk(1, 0, 1, 0, 63, 0, 0, 1));
    rows.push_back(mk(1, 0, 1, 0, 0, 'h77, 1, 1));
    rows.push_back(mk(1, 0, 1, 0, 1, 'h77, 0, 0));
    rows.push_back(mk(1, 0, 1, 0, 2, 'h77, 0, 1));
    rows.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    run_rows("wide");

    // Standalone adder
    for (int k = 0; k < 16; k++) begin
      int sel, av, bv, iv, im, src;
      sel = int'($urandom_range(0, 3));
      av = int'($urandom_range(0, 15)); bv = int'($urandom_range(0, 15));
      iv = int'($urandom_range(0, 15)); im = int'($urandom_range(0, 15));
      alu_bus_tb.src_sel = src_sel_e'(2'(sel));
      alu_bus_tb.a = 4'(av); alu_bus_tb.b = 4'(bv);
      alu_bus_tb.in_val = 4'(iv); alu_bus_tb.imm = 4'(im);
      #1;
      src = (sel == 0) ? av : (sel == 1) ? bv : (sel == 2) ? iv : 0;
      check($sformatf("alu[%0d].sum", k), 32'(alu_bus_tb.sum), (src + im) % 16);
      check($sformatf("alu[%0d].carry", k), 32'(alu_bus_tb.carry_out), (src + im) / 16);
    end

    // Random programs and controls against the model
    foreach (mem4[i]) mem4[i] = 8'($urandom_range(0, 255));
    m = '{default: 0};
    for (int k = 0; k < 400; k++) begin
      bit r, e;
      int d;
      r = (k == 0) || ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = int'($urandom_range(0, 15));
      rst4 = r; en4 = e; in4 = 4'(d);
      m = model_step(m, int'(mem4[m.pc]), r, e, d);
      @(posedge clk); #1;
      check($sformatf("rnd[%0d].addr", k), 32'(addr4), m.pc);
      check($sformatf("rnd[%0d].out", k), 32'(out4), m.out);
      check($sformatf("rnd[%0d].vld", k), 32'(vld4), m.vld);
      check($sformatf("rnd[%0d].carry", k), 32'(carry4), m.c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
